// File: rtl/bht_predictor.sv
// Bimodal branch predictor: 64 two-bit counters indexed by PC[7:2].
// Define BHT_STATS_EN to build the branch / mispredict counters.
module bht_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] CurrentPC,
  input  logic        BTBhit,
  input  logic [31:0] PrePC,
  input  logic        StallD,
  input  logic        StallE,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic [31:0] EXpc,
  input  logic [31:0] BrNPC,
  output logic        PredTaken,
  output logic [31:0] PredNPC,
  output logic        MispredE,
  output logic [31:0] RedirectPC,
  output logic [31:0] BrCnt,
  output logic [31:0] MissCnt
);

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
  } pred_t;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] ST = 2'b11;

  logic [1:0] ctr [64];
  logic [1:0] ctr_nxt;
  logic [5:0] rd_idx;
  logic [5:0] wr_idx;
  logic       upd;
  pred_t      pred_f;
  pred_t      pred_d;
  pred_t      pred_e;

  assign rd_idx = CurrentPC[7:2];
  assign wr_idx = EXpc[7:2];
  assign upd    = BrInstE & ~StallE;

  assign PredTaken = ~rst & BTBhit & ctr[rd_idx][1];
  assign PredNPC   = PredTaken ? PrePC : CurrentPC + 32'd4;
  assign pred_f    = '{taken: PredTaken, npc: PredNPC};

  assign MispredE = ~rst & BrInstE &
    ((pred_e.taken != BranchE) |
     (pred_e.taken & BranchE & (pred_e.npc != BrNPC)));

  assign RedirectPC = BranchE ? BrNPC : EXpc + 32'd4;

  // Saturating step of the counter addressed by the EX branch.
  always_comb begin
    ctr_nxt = ctr[wr_idx];
    if (BranchE) begin
      if (ctr[wr_idx] != ST) ctr_nxt = ctr[wr_idx] + 2'd1;
    end else begin
      if (ctr[wr_idx] != SN) ctr_nxt = ctr[wr_idx] - 2'd1;
    end
  end

  // Counter table: reset to weakly not-taken, train on resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ctr[i] <= WN;
    end else if (upd) begin
      ctr[wr_idx] <= ctr_nxt;
    end
  end

  // Prediction pipeline F->D: flush clears, stall holds.
  always_ff @(posedge clk) begin
    if (rst || FlushD) pred_d <= '0;
    else if (!StallD)  pred_d <= pred_f;
  end

  // Prediction pipeline D->E: flush clears, stall holds.
  always_ff @(posedge clk) begin
    if (rst || FlushE) pred_e <= '0;
    else if (!StallE)  pred_e <= pred_d;
  end

`ifdef BHT_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  // Count resolved branches and the ones that needed a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (upd) begin
      br_cnt <= br_cnt + 32'd1;
      if (MispredE) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign BrCnt   = br_cnt;
  assign MissCnt = miss_cnt;
`else
  assign BrCnt   = '0;
  assign MissCnt = '0;
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: per-cycle model compare plus
// directed literal expectations.
`timescale 1ns/1ps
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] CurrentPC;
  logic        BTBhit;
  logic [31:0] PrePC;
  logic        StallD, StallE, FlushD, FlushE;
  logic        BrInstE, BranchE;
  logic [31:0] EXpc, BrNPC;
  logic        PredTaken;
  logic [31:0] PredNPC;
  logic        MispredE;
  logic [31:0] RedirectPC;
  logic [31:0] BrCnt, MissCnt;

  int errs   = 0;
  int checks = 0;

  bht_predictor dut (
    .clk(clk), .rst(rst),
    .CurrentPC(CurrentPC), .BTBhit(BTBhit), .PrePC(PrePC),
    .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .BrInstE(BrInstE), .BranchE(BranchE),
    .EXpc(EXpc), .BrNPC(BrNPC),
    .PredTaken(PredTaken), .PredNPC(PredNPC),
    .MispredE(MispredE), .RedirectPC(RedirectPC),
    .BrCnt(BrCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  // model: counter strength 0..3, taken when >= 2
  int          mc [64];
  bit          md_t, me_t;
  bit   [31:0] md_n, me_n;
  bit   [31:0] m_br, m_miss;

  function automatic bit m_pt();
    return !rst && BTBhit && (mc[CurrentPC[7:2]] >= 2);
  endfunction

  function automatic bit [31:0] m_npc();
    return m_pt() ? PrePC : CurrentPC + 32'd4;
  endfunction

  // wrong if direction differs, or taken with the wrong target
  function automatic bit m_mis();
    if (rst || !BrInstE) return 1'b0;
    if (me_t != BranchE) return 1'b1;
    return BranchE && (me_n != BrNPC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit          pt, mis;
    bit   [31:0] npc;
    int          i;
    pt  = m_pt();
    npc = m_npc();
    mis = m_mis();
    if (rst) begin
      for (int k = 0; k < 64; k++) mc[k] = 1;
      md_t = 0; md_n = 0; me_t = 0; me_n = 0;
      m_br = 0; m_miss = 0;
    end else begin
      if (BrInstE && !StallE) begin
        i = int'(EXpc[7:2]);
        m_br = m_br + 1;
        if (mis) m_miss = m_miss + 1;
        if (BranchE) mc[i] = (mc[i] < 3) ? mc[i] + 1 : 3;
        else         mc[i] = (mc[i] > 0) ? mc[i] - 1 : 0;
      end
      if (FlushE)       begin me_t = 0; me_n = 0; end
      else if (!StallE) begin me_t = md_t; me_n = md_n; end
      if (FlushD)       begin md_t = 0; md_n = 0; end
      else if (!StallD) begin md_t = pt; md_n = npc; end
    end
  end

  always @(negedge clk) begin
    chk("pred_taken", {31'd0, PredTaken}, {31'd0, m_pt()});
    chk("pred_npc", PredNPC, m_npc());
    chk("mispred", {31'd0, MispredE}, {31'd0, m_mis()});
    if (m_mis())
      chk("redirect", RedirectPC, BranchE ? BrNPC : EXpc + 32'd4);
`ifdef BHT_STATS_EN
    chk("br_cnt", BrCnt, m_br);
    chk("miss_cnt", MissCnt, m_miss);
`else
    chk("br_cnt", BrCnt, 32'd0);
    chk("miss_cnt", MissCnt, 32'd0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; CurrentPC = 32'h40; BTBhit = 1; PrePC = 32'h100;
    StallD = 0; StallE = 0; FlushD = 0; FlushE = 0;
    BrInstE = 0; BranchE = 0; EXpc = 0; BrNPC = 0;
    step(); step();
    rst = 0;
    #1;
    chk("reset_pt", {31'd0, PredTaken}, 32'd0);
    chk("reset_npc", PredNPC, 32'h44);

    BrInstE = 1; BranchE = 1; EXpc = 32'h40; BrNPC = 32'h100;
    step(); step();
    BrInstE = 0;
    #1;
    chk("st_pt", {31'd0, PredTaken}, 32'd1);
    chk("st_npc", PredNPC, 32'h100);
    BTBhit = 0;
    #1;
    chk("nobtb_pt", {31'd0, PredTaken}, 32'd0);
    chk("nobtb_npc", PredNPC, 32'h44);
    BTBhit = 1;

    step(); step();
    StallD = 1; StallE = 1;
    #1;
    chk("nonbr_mis", {31'd0, MispredE}, 32'd0);
    BrInstE = 1; BranchE = 0; EXpc = 32'h40;
    #1;
    chk("nt_mis", {31'd0, MispredE}, 32'd1);
    chk("nt_redir", RedirectPC, 32'h44);
    step();
    BranchE = 1; BrNPC = 32'h100;
    #1;
    chk("tgt_ok_mis", {31'd0, MispredE}, 32'd0);
    BrNPC = 32'h200;
    #1;
    chk("tgt_bad_mis", {31'd0, MispredE}, 32'd1);
    chk("tgt_bad_redir", RedirectPC, 32'h200);
    step();
    BranchE = 0;
    step();
    BrInstE = 0;
    #1;
    chk("stall_ctr_pt", {31'd0, PredTaken}, 32'd1);
    FlushE = 1;
    step();
    FlushE = 0; BrInstE = 1; BranchE = 0;
    #1;
    chk("flushe_nt_mis", {31'd0, MispredE}, 32'd0);
    BranchE = 1;
    #1;
    chk("flushe_t_mis", {31'd0, MispredE}, 32'd1);
    chk("flushe_redir", RedirectPC, 32'h200);
    BrInstE = 0; StallD = 0; StallE = 0;

    BrInstE = 1; BranchE = 0; EXpc = 32'h40;
    step();
    #1;
    chk("wt_pt", {31'd0, PredTaken}, 32'd1);
    step();
    #1;
    chk("wn_pt", {31'd0, PredTaken}, 32'd0);
    step(); step();
    BranchE = 1;
    step();
    BrInstE = 0;
    #1;
    chk("sn_sat_pt", {31'd0, PredTaken}, 32'd0);
    BrInstE = 1;
    step();
    BrInstE = 0;
    #1;
    chk("sn_wt_pt", {31'd0, PredTaken}, 32'd1);

    BrInstE = 1; BranchE = 0;
    #1;
    chk("rbw_pt", {31'd0, PredTaken}, 32'd1);
    step();
    BrInstE = 0;
    #1;
    chk("rbw_after_pt", {31'd0, PredTaken}, 32'd0);

    BrInstE = 1; BranchE = 1; EXpc = 32'hFC; BrNPC = 32'h300;
    step(); step();
    BrInstE = 0; CurrentPC = 32'hFC;
    #1;
    chk("idx63_pt", {31'd0, PredTaken}, 32'd1);
    CurrentPC = 32'h3C;
    #1;
    chk("idx15_pt", {31'd0, PredTaken}, 32'd0);
    CurrentPC = 32'h140;
    #1;
    chk("alias_pt", {31'd0, PredTaken}, 32'd0);
    step();
    CurrentPC = 32'hFFFFFFFC; BTBhit = 0;
    #1;
    chk("wrap_npc", PredNPC, 32'h0);
    BTBhit = 1;
    #1;
    chk("wrap_taken_npc", PredNPC, 32'h100);

    BrInstE = 1; BranchE = 1; EXpc = 32'hFC; rst = 1;
    #1;
    chk("rst_pt", {31'd0, PredTaken}, 32'd0);
    chk("rst_mis", {31'd0, MispredE}, 32'd0);
    chk("rst_npc", PredNPC, 32'h0);
    step();
    rst = 0; BrInstE = 0; CurrentPC = 32'hFC;
    #1;
    chk("rst_discard_pt", {31'd0, PredTaken}, 32'd0);

    FlushD = 1; FlushE = 1; BrInstE = 1; BrNPC = 32'h100;
    for (int k = 0; k < 5; k++) begin
      BranchE = (k % 2 == 1);
      step();
    end
    BrInstE = 0;
    #1;
`ifdef BHT_STATS_EN
    chk("stats_br", BrCnt, 32'd5);
    chk("stats_miss", MissCnt, 32'd2);
    dut.br_cnt = 32'hFFFFFFFF;
    m_br = 32'hFFFFFFFF;
    BrInstE = 1; BranchE = 0;
    step();
    BrInstE = 0;
    #1;
    chk("stats_wrap", BrCnt, 32'd0);
`else
    chk("stats_br_off", BrCnt, 32'd0);
    chk("stats_miss_off", MissCnt, 32'd0);
`endif
    FlushD = 0; FlushE = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port CurrentPC, input, 32, fetch-stage PC for lookup.
REQ-004 SHALL have ports BTBhit (input, 1) and PrePC (input, 32): BTB hit flag and target for CurrentPC.
REQ-005 SHALL have ports StallD, StallE, FlushD, FlushE, input, 1 each, from hazard unit.
REQ-006 SHALL have ports BrInstE (input, 1) and BranchE (input, 1): EX holds a conditional branch, and its actual direction.
REQ-007 SHALL have ports EXpc (input, 32) and BrNPC (input, 32): EX branch PC and resolved taken target.
REQ-008 SHALL have ports PredTaken (output, 1) and PredNPC (output, 32): fetch next-PC choice.
REQ-009 SHALL have ports MispredE (output, 1) and RedirectPC (output, 32): EX correction request.
REQ-010 SHALL have ports BrCnt and MissCnt, output, 32 each, performance counters (see Configuration).

Function
REQ-011 SHALL hold 64 two-bit counters indexed by PC[7:2]; states SN=00, WN=01, WT=10, ST=11.
REQ-012 PredTaken SHALL be combinational: BTBhit AND counter[CurrentPC[7:2]][1]; forced 0 while rst=1.
REQ-013 PredNPC SHALL equal PrePC when PredTaken=1, else CurrentPC+4 (mod 2^32).
REQ-014 SHALL carry {PredTaken, PredNPC} through registers F->D and D->E; a stage holds when its Stall is 1; a stage loads {0, 0} when its Flush is 1; Flush wins over Stall.
REQ-015 When BrInstE=1 and StallE=0, the counter at EXpc[7:2] SHALL step on the next edge: BranchE=1 -> SN->WN->WT->ST, ST stays ST; BranchE=0 -> ST->WT->WN->SN, SN stays SN.
REQ-016 Counters SHALL not change when BrInstE=0 or StallE=1.
REQ-017 Lookup and update to the same index in one cycle SHALL return the pre-update counter value (read-before-write).
REQ-018 MispredE SHALL be combinational: BrInstE AND ((PredE != BranchE) OR (PredE AND BranchE AND PredNPCE != BrNPC)).
REQ-019 RedirectPC SHALL equal BrNPC when BranchE=1, else EXpc+4; value is don't-care when MispredE=0.
REQ-020 A non-branch in EX (BrInstE=0) SHALL never assert MispredE, whatever PredE holds.

Reset
REQ-021 On rst=1 at a rising edge, all 64 counters SHALL become WN (01).
REQ-022 On rst=1, D/E prediction registers SHALL become {0, 0}; BrCnt and MissCnt SHALL become 0.
REQ-023 While rst=1: PredTaken=0, MispredE=0, PredNPC=CurrentPC+4.
REQ-024 Reset asserted mid-operation SHALL discard pending updates of that cycle; reset has priority over stall, flush and update.

Configuration
REQ-025 Macro BHT_STATS_EN SHALL gate the performance counters.
REQ-026 With BHT_STATS_EN defined: BrCnt +1 per edge with BrInstE=1 and StallE=0; MissCnt +1 on those edges when MispredE=1; both wrap 0xFFFFFFFF->0.
REQ-027 Without BHT_STATS_EN: ports BrCnt and MissCnt SHALL remain present and tie to 0, with no counter registers synthesized.

Verification
REQ-028 Reset, then CurrentPC=0x00000040, BTBhit=1, PrePC=0x00000100 -> PredTaken=0, PredNPC=0x00000044 (WN).
REQ-029 Two taken updates to EXpc=0x00000040 (BrInstE=1, BranchE=1) -> counter WN->WT->ST; same lookup -> PredTaken=1, PredNPC=0x00000100.
REQ-030 From ST: three not-taken updates -> ST->WT->WN->SN; a fourth leaves SN; BTBhit=0 at any state -> PredTaken=0.
REQ-031 Predicted taken to 0x100 reaches EX, BranchE=0, EXpc=0x40 -> MispredE=1, RedirectPC=0x00000044; with BranchE=1, BrNPC=0x100 -> MispredE=0; BrNPC=0x200 -> MispredE=1, RedirectPC=0x00000200.
REQ-032 StallE=1 with BrInstE=1 -> counter unchanged, E register held; FlushE=1 and StallE=1 together -> E register {0, 0}.
REQ-033 With BHT_STATS_EN: 5 resolved branches, 2 mispredicted -> BrCnt=5, MissCnt=2; preload BrCnt=0xFFFFFFFF then one branch -> BrCnt=0; without macro -> both read 0.
